response_logger: RTL
====================

Name: response_logger

Overview:
- Receiving end of the gate test-vector flow. Captures a stream of applied-vector/response samples ({b, a, y} for a 2-input gate) from a bench-side or BIST-side vector applier.
- Stores the samples in a small buffer and compacts them into a MISR signature. After capture, the samples are replayed out over a valid/ready read port for dump and compare.
- Sits beside a DUT gate, for example a NAND2, and turns per-cycle vector checking into a post-run readback.

Parameters:
- DW, 3, sample width (stimulus bits plus response bit).
- DEPTH, 8, buffer entries; must be at least 2.
- SIGW, 8, signature width; must be at least DW.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; clears the buffer and starts a capture.
- in_valid  input  1  a sample is offered.
- in_ready  output  1  the logger can accept a sample this cycle.
- in_data  input  DW  sample, e.g. {b, a, y}.
- in_last  input  1  qualifies the final sample of a run.
- rd_valid  output  1  readback data is valid.
- rd_ready  input  1  the consumer takes the readback data.
- rd_data  output  DW  stored sample at the read pointer.
- count  output  $clog2(DEPTH+1)  number of samples captured.
- signature  output  SIGW  running MISR value.
- done  output  1  the run has been captured and fully read back.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; wptr=rptr=0; count=0; signature=SEED.
  - in_ready=0, rd_valid=0, done=0, rd_data=0.
  - Buffer contents are don't-care.
- States: IDLE, CAPTURE, DUMP, DONE.
- IDLE:
  - in_ready=0, rd_valid=0.
  - start -> CAPTURE; same edge clears wptr, rptr, count and loads signature=SEED.
- CAPTURE:
  - in_ready=1.
  - Accept when in_valid && in_ready: mem[wptr]<=in_data; wptr++; count++; signature<=misr(signature, in_data). All updates land on the same edge.
  - Go to DUMP on the accepting edge if in_last=1 or count becomes DEPTH. in_ready is therefore 0 from the next cycle; no overflow is possible.
  - in_valid=0 cycles change nothing.
- DUMP:
  - in_ready=0.
  - rd_valid=1 while rptr<count; rd_data=mem[rptr], combinational from the registered buffer.
  - On rd_valid && rd_ready: rptr++. If that transfer is the final one (rptr==count-1), go to DONE.
  - rd_data is held stable while rd_valid && !rd_ready.
- DONE:
  - done=1; count and signature hold; rd_valid=0, in_ready=0.
  - start -> CAPTURE with a full clear.
- MISR (SIGW bits):
  - next = {s[SIGW-2:0], s[SIGW-1]} ^ ({SIGW{s[SIGW-1]}} & POLY) ^ zero-extended in_data.
  - POLY=8'h1D, SEED=8'hFF.
  - Updates only on accepted samples.
- Boundaries:
  - start in CAPTURE or DUMP aborts the run: clear, then CAPTURE. start has priority over a simultaneous accept or read.
  - in_last together with the DEPTH-th sample: single transition to DUMP.
  - Pointers never wrap within a run; both clear on start.
  - reset_n asserted mid-run: immediate return to reset values; the next run requires start.
  - count is always at least 1 on entering DUMP.

Decomposition:
- Package response_logger_pkg holds:
  - typedef enum logic [1:0] {IDLE, CAPTURE, DUMP, DONE} logger_state_t;
  - localparams MISR_POLY=8'h1D and MISR_SEED=8'hFF.
- One sub-module, misr_step: purely combinational next-signature function parameterised by SIGW/DW/POLY. It is reused by the bench's reference model.

Test Plan:
1. Reset, then start; send one sample 3'b011 with in_last -> count=1, signature=8'hE1, DUMP; rd_data=3'b011 on the first rd_ready; done=1 the next cycle.
2. NAND2 truth-table run: {b,a,y}=001,011,101,110, last on 110 -> count=4, readback in order, signature matches the misr_step model, done=1.
3. Send 9 samples with no in_last, DEPTH=8 -> in_ready drops after the 8th, count=8, the 9th sample is not accepted, DUMP returns exactly 8 entries.
4. Readback with rd_ready toggling 1,0,0,1 -> rd_data held while stalled; no entry skipped or duplicated.
5. start pulsed mid-CAPTURE after 3 samples -> count=0, signature=8'hFF next cycle, new run captures cleanly.
6. reset_n low during DUMP -> outputs immediately at reset values; IDLE until start.

Source files
------------

// File: rtl/response_logger_pkg.sv
// Shared types and constants for the response logger.
// Holds the controller state encoding and the MISR polynomial/seed.
package response_logger_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, DUMP, DONE} logger_state_t;

  localparam logic [7:0] MISR_POLY = 8'h1D;
  localparam logic [7:0] MISR_SEED = 8'hFF;

endpackage

// File: rtl/misr_step.sv
// One combinational MISR step: rotate left, fold the polynomial in when the
// outgoing MSB is set, then XOR the zero-extended sample.
// Ports:
//   sig      : current signature
//   data     : sample being compacted
//   sig_next : signature after absorbing data
module misr_step #(
  parameter int unsigned     SIGW = 8,
  parameter int unsigned     DW   = 3,
  parameter logic [SIGW-1:0] POLY = 'h1D
) (
  input  logic [SIGW-1:0] sig,
  input  logic [DW-1:0]   data,
  output logic [SIGW-1:0] sig_next
);

  assign sig_next = {sig[SIGW-2:0], sig[SIGW-1]}
                  ^ ({SIGW{sig[SIGW-1]}} & POLY)
                  ^ SIGW'(data);

endmodule

// File: rtl/response_logger.sv
// Captures applied-vector/response samples into a small buffer, compacts them
// into a MISR signature, then replays the buffer over a valid/ready port.
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   start                  : clear and begin a capture (any state)
//   in_valid/in_ready      : sample handshake; in_data sample, in_last ends run
//   rd_valid/rd_ready      : readback handshake; rd_data stored sample
//   count                  : samples captured this run
//   signature              : running MISR value
//   done                   : run captured and fully read back
module response_logger
  import response_logger_pkg::*;
#(
  parameter int unsigned DW    = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SIGW  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_last,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [SIGW-1:0]            signature,
  output logic                       done
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logger_state_t state_q, state_d;

  // count_q doubles as the write pointer: entries are written in order from 0.
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   rptr_q;
  logic [SIGW-1:0] sig_q;
  logic [SIGW-1:0] sig_next;
  logic [DW-1:0]   mem_q [DEPTH];

  logic accept;
  logic rd_fire;
  logic last_read;

  assign accept    = in_valid && in_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign last_read = (rptr_q == count_q - CW'(1));

  misr_step #(
    .SIGW (SIGW),
    .DW   (DW),
    .POLY (SIGW'(MISR_POLY))
  ) u_misr_step (
    .sig      (sig_q),
    .data     (in_data),
    .sig_next (sig_next)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start wins over any simultaneous accept or read.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = CAPTURE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        CAPTURE: begin
          if (accept && (in_last || count_q == CW'(DEPTH - 1))) state_d = DUMP;
        end
        DUMP:    begin
          if (rd_fire && last_read) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    in_ready = (state_q == CAPTURE);
    rd_valid = (state_q == DUMP) && (rptr_q < count_q);
    done     = (state_q == DONE);
    rd_data  = '0;
    if (rd_valid) rd_data = mem_q[rptr_q[AW-1:0]];
  end

  // Pointers and signature.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      rptr_q  <= '0;
      sig_q   <= SIGW'(MISR_SEED);
    end else if (start) begin
      count_q <= '0;
      rptr_q  <= '0;
      sig_q   <= SIGW'(MISR_SEED);
    end else if (accept) begin
      count_q <= count_q + CW'(1);
      sig_q   <= sig_next;
    end else if (rd_fire) begin
      rptr_q  <= rptr_q + CW'(1);
    end
  end

  // Sample storage; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk) begin
    if (accept && !start) mem_q[count_q[AW-1:0]] <= in_data;
  end

  assign count     = count_q;
  assign signature = sig_q;

endmodule
